// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types, defaults and helpers for the audio sink path
// Purpose: default stream/frame geometry, sample type and counter-width helpers
//          used by i2s_tx and i2s_clkgen.
// Ports:   none (package).
package audio_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_SLOT_WIDTH   = 32;
  localparam int DEF_CLK_PER_BCLK = 8;
  localparam int FRAME_BITS       = 2 * DEF_SLOT_WIDTH;

  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

  // BCLK periods in one stereo frame for a given slot width.
  function automatic int frame_bits(input int slot_width);
    return 2 * slot_width;
  endfunction

  // Register width needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK/LRCLK generator and frame bit counter
// Purpose: divides clk down to BCLK, counts bit positions across a stereo
//          frame and drives the word-select line.
// Ports:   clk, rst         - system clock, async active-high reset
//          bclk, lrclk      - registered I2S bit clock and word select
//          bit_next         - bit index that will be current after this edge
//          bclk_fall        - this edge is a BCLK falling edge
//          frame_start      - this edge starts a new frame (bit index wraps to 0)
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
  parameter int CLK_PER_BCLK = DEF_CLK_PER_BCLK,
  parameter int BIT_W        = cnt_width(frame_bits(DEF_SLOT_WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  output logic             bclk,
  output logic             lrclk,
  output logic [BIT_W-1:0] bit_next,
  output logic             bclk_fall,
  output logic             frame_start
);

  localparam int DIV_W = cnt_width(CLK_PER_BCLK);
  localparam int FB    = frame_bits(SLOT_WIDTH);

  if (CLK_PER_BCLK < 2 || (CLK_PER_BCLK % 2) != 0) begin : g_bad_div
    $error("i2s_clkgen: CLK_PER_BCLK must be even and >= 2");
  end
  if (BIT_W < cnt_width(FB)) begin : g_bad_bitw
    $error("i2s_clkgen: BIT_W too narrow for the frame length");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [BIT_W-1:0] bit_cnt;

  always_comb begin
    bclk_fall   = (div_cnt == DIV_W'(CLK_PER_BCLK - 1));
    frame_start = bclk_fall && (bit_cnt == BIT_W'(FB - 1));
    div_next    = bclk_fall ? '0 : div_cnt + 1'b1;
    if (frame_start) begin
      bit_next = '0;
    end else if (bclk_fall) begin
      bit_next = bit_cnt + 1'b1;
    end else begin
      bit_next = bit_cnt;
    end
  end

  // bclk/lrclk are computed from the next counter values so the registered
  // outputs always agree with the counters they sit beside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else begin
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      bclk    <= (div_next >= DIV_W'(CLK_PER_BCLK / 2));
      // Word select leads the slot data by one BCLK.
      lrclk   <= (bit_next >= BIT_W'(SLOT_WIDTH - 1)) && (bit_next <= BIT_W'(FB - 2));
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - mono sample stream to Philips-I2S DAC serialiser
// Purpose: holds one incoming sample, loads it at each frame start and sends
//          it MSB-first, left-justified, in both the left and right slots.
// Ports:   clk, rst         - system clock, async active-high reset
//          data_i, vld_i    - sample stream, single-cycle valid, no backpressure
//          bclk_o, lrclk_o  - I2S bit clock and word select (0 = left)
//          sdata_o          - I2S serial data, changes on BCLK falling edge
//          frame_o          - pulse when a frame starts (sample loaded)
//          udf_o            - pulse when a frame starts with no new sample
//          ovf_o            - pulse when an unconsumed held sample is overwritten
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
  parameter int CLK_PER_BCLK = DEF_CLK_PER_BCLK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic                  bclk_o,
  output logic                  lrclk_o,
  output logic                  sdata_o,
  output logic                  frame_o,
  output logic                  udf_o,
  output logic                  ovf_o
);

  localparam int BIT_W = cnt_width(frame_bits(SLOT_WIDTH));

  if (DATA_WIDTH < 1 || SLOT_WIDTH < DATA_WIDTH) begin : g_bad_width
    $error("i2s_tx: need 1 <= DATA_WIDTH <= SLOT_WIDTH");
  end

  logic [BIT_W-1:0]      bit_next;
  logic                  bclk_fall;
  logic                  frame_start;

  logic [DATA_WIDTH-1:0] hold, hold_next;
  logic                  hold_full, hold_full_next;
  logic [DATA_WIDTH-1:0] sample, sample_next;
  logic [DATA_WIDTH-1:0] sample_shift;
  logic [BIT_W-1:0]      slot_pos;
  logic                  sdata_next;
  logic                  udf_next;
  logic                  ovf_next;

  i2s_clkgen #(
    .SLOT_WIDTH   (SLOT_WIDTH),
    .CLK_PER_BCLK (CLK_PER_BCLK),
    .BIT_W        (BIT_W)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .bclk        (bclk_o),
    .lrclk       (lrclk_o),
    .bit_next    (bit_next),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start)
  );

  always_comb begin
    hold_next      = hold;
    hold_full_next = hold_full;
    sample_next    = sample;
    udf_next       = 1'b0;
    ovf_next       = 1'b0;

    if (vld_i) begin
      hold_next      = data_i;
      hold_full_next = 1'b1;
      // At a frame start the held value is retired this cycle, so a new beat
      // replaces nothing that was still waiting.
      ovf_next       = hold_full && !frame_start;
    end

    if (frame_start) begin
      hold_full_next = 1'b0;
      if (vld_i) begin
        sample_next = data_i;
      end else if (hold_full) begin
        sample_next = hold;
      end else begin
        udf_next = 1'b1;
      end
    end

    // Position within the current slot; bits beyond the sample width are zero.
    slot_pos     = (bit_next >= BIT_W'(SLOT_WIDTH)) ? bit_next - BIT_W'(SLOT_WIDTH) : bit_next;
    sample_shift = sample_next << slot_pos;
    sdata_next   = (slot_pos < BIT_W'(DATA_WIDTH)) && sample_shift[DATA_WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      sample    <= '0;
      sdata_o   <= 1'b0;
      frame_o   <= 1'b0;
      udf_o     <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      hold      <= hold_next;
      hold_full <= hold_full_next;
      sample    <= sample_next;
      // sdata only moves when bit_next moves, i.e. on a BCLK fall.
      sdata_o   <= sdata_next;
      frame_o   <= frame_start;
      udf_o     <= udf_next;
      ovf_o     <= ovf_next;
    end
  end

  logic unused_fall;
  assign unused_fall = bclk_fall;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - scoreboard bench for i2s_tx
module tb_i2s_tx;

  localparam int DW   = 8;
  localparam int SW   = 8;
  localparam int CPB  = 4;
  localparam int FRM  = 2 * SW * CPB;
  localparam int SWB  = 32;
  localparam int NW   = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] data_a = '0;
  logic          vld_a  = 1'b0;
  logic bclk_a, lrclk_a, sdata_a, frame_a, udf_a, ovf_a;

  logic [DW-1:0] data_b = '0;
  logic          vld_b  = 1'b0;
  logic bclk_b, lrclk_b, sdata_b, frame_b, udf_b, ovf_b;

  i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CLK_PER_BCLK(CPB)) dut_a (
    .clk(clk), .rst(rst), .data_i(data_a), .vld_i(vld_a),
    .bclk_o(bclk_a), .lrclk_o(lrclk_a), .sdata_o(sdata_a),
    .frame_o(frame_a), .udf_o(udf_a), .ovf_o(ovf_a)
  );

  i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SWB), .CLK_PER_BCLK(CPB)) dut_b (
    .clk(clk), .rst(rst), .data_i(data_b), .vld_i(vld_b),
    .bclk_o(bclk_b), .lrclk_o(lrclk_b), .sdata_o(sdata_b),
    .frame_o(frame_b), .udf_o(udf_b), .ovf_o(ovf_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected serial word for a frame: sample left-justified in each slot.
  function automatic logic [63:0] exp_sd(input logic [DW-1:0] d, input int sw);
    logic [63:0] slot;
    slot = 64'(d) << (sw - DW);
    return (slot << sw) | slot;
  endfunction

  // Expected word-select pattern, one bit per BCLK, MSB = first bit of frame.
  function automatic logic [63:0] exp_lr(input int sw);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 2 * sw; b++) w = {w[62:0], (b >= sw - 1 && b <= 2 * sw - 2)};
    return w;
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    bit            udf;
    int            ovf;
  } exp_t;

  exp_t sb_q[$];

  int edge_n = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // Monitor: pops one expectation per frame_o and checks that frame.
  int          frames_seen = 0;
  int          frames_done = 0;
  bit          mon_active  = 1'b0;
  int          mk          = 0;
  int          ovf_cnt     = 0;
  int          bclk_err    = 0;
  logic [63:0] got_sd, got_lr;
  exp_t        cur;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      ovf_cnt    = 0;
    end else begin
      if (frame_a && frames_seen < NW) begin
        check("frame_time", 64'(edge_n), 64'(FRM * (frames_seen + 1)));
        if (sb_q.size() == 0) begin
          check("sb_nonempty", 64'(0), 64'(1));
        end else begin
          cur = sb_q.pop_front();
          check("udf", 64'(udf_a), 64'(cur.udf));
          check("ovf_count", 64'(ovf_cnt), 64'(cur.ovf));
        end
        frames_seen++;
        mon_active = 1'b1;
        mk         = 0;
        got_sd     = '0;
        got_lr     = '0;
        bclk_err   = 0;
        ovf_cnt    = 0;
      end
      if (mon_active) begin
        if (bclk_a !== ((mk % CPB) >= CPB / 2)) bclk_err++;
        if (mk % CPB == CPB / 2) begin
          got_sd = {got_sd[62:0], sdata_a};
          got_lr = {got_lr[62:0], lrclk_a};
        end
        if (mk == FRM - 1) begin
          check("sdata_word", got_sd, exp_sd(cur.data, SW));
          check("lrclk_word", got_lr, exp_lr(SW));
          check("bclk_shape", 64'(bclk_err), 64'(0));
          mon_active = 1'b0;
          frames_done++;
        end
        mk++;
      end
      ovf_cnt += int'(ovf_a);
    end
  end

  // Stimulus window w covers edges (FRM*(w-1), FRM*w]; its offsets are 1..FRM.
  bit            av [1:FRM];
  logic [DW-1:0] ad [1:FRM];
  logic [DW-1:0] prev_data = '0;

  initial begin
    exp_t e;
    int   n, o, last, pre;
    bit   found;
    logic [63:0] sd_b, lr_b;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bclk_a, lrclk_a, sdata_a, frame_a, udf_a, ovf_a}), 64'(0));
    rst = 1'b0;

    for (int w = 1; w <= NW; w++) begin
      for (int i = 1; i <= FRM; i++) begin
        av[i] = 1'b0;
        ad[i] = '0;
      end
      case (w)
        1: begin av[10] = 1'b1; ad[10] = 8'hA5; end
        2: ;
        3: begin av[5] = 1'b1; ad[5] = 8'h11; av[30] = 1'b1; ad[30] = 8'h22; end
        4: begin av[FRM] = 1'b1; ad[FRM] = 8'h3C; end
        default: begin
          n = $urandom_range(0, 3);
          for (int j = 0; j < n; j++) begin
            o = $urandom_range(1, FRM);
            av[o] = 1'b1;
            ad[o] = 8'($urandom);
          end
        end
      endcase

      // Reference: the last beat of the window is sent; every beat before the
      // frame-start edge beyond the first overwrites an unsent one.
      last = 0;
      pre  = 0;
      for (int i = 1; i <= FRM; i++) begin
        if (av[i]) begin
          last = i;
          if (i < FRM) pre++;
        end
      end
      e.udf  = (last == 0);
      e.data = (last == 0) ? prev_data : ad[last];
      e.ovf  = (pre > 1) ? pre - 1 : 0;
      prev_data = e.data;
      sb_q.push_back(e);

      for (int i = 1; i <= FRM; i++) begin
        vld_a  = av[i];
        data_a = av[i] ? ad[i] : 8'($urandom);
        @(negedge clk);
        if (w == 1 && i == 1)
          check("outputs_after_release", 64'({bclk_a, lrclk_a, sdata_a, frame_a, udf_a, ovf_a}), 64'(0));
      end
      vld_a = 1'b0;
    end

    found = 1'b0;
    for (int t = 0; t < 4 * FRM && !found; t++) begin
      if (frames_done == NW) found = 1'b1;
      else @(negedge clk);
    end
    check("all_frames_checked", 64'(found), 64'(1));
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    // Wide slot: bits past the sample are zero, lrclk one BCLK ahead of MSB.
    data_b = 8'hFF;
    vld_b  = 1'b1;
    @(negedge clk);
    vld_b  = 1'b0;
    found  = 1'b0;
    for (int t = 0; t < 2 * SWB * CPB + 16 && !found; t++) begin
      if (frame_b) found = 1'b1;
      else @(negedge clk);
    end
    check("wide_frame_seen", 64'(found), 64'(1));
    if (found) begin
      check("wide_udf", 64'(udf_b), 64'(0));
      sd_b = '0;
      lr_b = '0;
      for (int k = 0; k < 2 * SWB * CPB; k++) begin
        if (k % CPB == CPB / 2) begin
          sd_b = {sd_b[62:0], sdata_b};
          lr_b = {lr_b[62:0], lrclk_b};
        end
        @(negedge clk);
      end
      check("wide_sdata_word", sd_b, exp_sd(8'hFF, SWB));
      check("wide_lrclk_word", lr_b, exp_lr(SWB));
    end

    // Asynchronous reset in the middle of a right slot.
    found = 1'b0;
    for (int t = 0; t < 2 * FRM && !found; t++) begin
      if (lrclk_a && !frame_a) found = 1'b1;
      else @(negedge clk);
    end
    check("right_slot_reached", 64'(found), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_reset_a", 64'({bclk_a, lrclk_a, sdata_a, frame_a, udf_a, ovf_a}), 64'(0));
    check("async_reset_b", 64'({bclk_b, lrclk_b, sdata_b, frame_b, udf_b, ovf_b}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
